// File: rtl/enq_issue_ctrl_pkg.sv
// Shared definitions for the enqueue/issue controller: FSM encoding and default sizes.
package enq_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int DEF_CMDQ_DEPTH   = 4;
    localparam int DEF_XIMM1Q_DEPTH = 4;
    localparam int DEF_CMD_W        = 8;
    localparam int DEF_IMM_W        = 32;
    localparam int DEF_STARVE_LIMIT = 15;

endpackage

// File: rtl/enq_issue_ctrl_credit_counter.sv
// Per-queue credit counter: decrements on use, increments on return, saturates at DEPTH.
module credit_counter #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         use_i,
    input  logic                         ret_i,
    output logic [$clog2(DEPTH+1)-1:0]   cred_o,
    output logic                         nonzero_o,
    output logic                         full_o,
    output logic                         ovf_o
);
    localparam int W = $clog2(DEPTH + 1);

    logic [W-1:0] cred_q;
    logic [W-1:0] cred_d;
    logic         ovf_s;

    assign full_o    = (cred_q == W'(DEPTH));
    assign nonzero_o = (cred_q != {W{1'b0}});
    assign cred_o    = cred_q;
    assign ovf_o     = ovf_s;

    // Next credit value; a return into a full counter is dropped and flagged.
    always_comb begin
        cred_d = cred_q;
        ovf_s  = 1'b0;
        if (use_i && !ret_i && nonzero_o) begin
            cred_d = cred_q - W'(1);
        end else if (ret_i && !use_i) begin
            if (full_o) begin
                ovf_s = 1'b1;
            end else begin
                cred_d = cred_q + W'(1);
            end
        end else begin
            cred_d = cred_q;
        end
    end

    // Credit register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cred_q <= W'(DEPTH);
        end else begin
            cred_q <= cred_d;
        end
    end

endmodule

// File: rtl/enq_issue_ctrl.sv
// Issue controller: credit-gated atomic dual-enqueue into cmdq/ximm1q with stall, drain and starvation tracking.
module enq_issue_ctrl
    import enq_issue_ctrl_pkg::*;
#(
    parameter int CMDQ_DEPTH   = DEF_CMDQ_DEPTH,
    parameter int XIMM1Q_DEPTH = DEF_XIMM1Q_DEPTH,
    parameter int CMD_W        = DEF_CMD_W,
    parameter int IMM_W        = DEF_IMM_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              io_valid,
    input  logic                              io_sigs_enq_cmdq,
    input  logic                              io_sigs_enq_ximm1q,
    input  logic [CMD_W-1:0]                  io_cmd,
    input  logic [IMM_W-1:0]                  io_imm,
    output logic                              io_replay,
    output logic                              io_cmdq_valid,
    output logic [CMD_W-1:0]                  io_cmdq_bits,
    output logic                              io_ximm1q_valid,
    output logic [IMM_W-1:0]                  io_ximm1q_bits,
    input  logic                              io_cmdq_deq,
    input  logic                              io_ximm1q_deq,
    input  logic                              io_flush,
    output logic [$clog2(CMDQ_DEPTH+1)-1:0]   io_cmdq_credits,
    output logic [$clog2(XIMM1Q_DEPTH+1)-1:0] io_ximm1q_credits,
    output logic                              io_starve,
    output logic                              io_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_e            state_q;
    logic              cmdq_valid_q, ximm_valid_q;
    logic [CMD_W-1:0]  cmd_bits_q;
    logic [IMM_W-1:0]  imm_bits_q;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              starve_q, err_q;

    logic c_nonzero_s, c_full_s, c_ovf_s;
    logic x_nonzero_s, x_full_s, x_ovf_s;
    logic ok_c_s, ok_x_s, issue_ok_s, fire_s, use_c_s, use_x_s;

    assign ok_c_s     = !io_sigs_enq_cmdq   || c_nonzero_s;
    assign ok_x_s     = !io_sigs_enq_ximm1q || x_nonzero_s;
    assign issue_ok_s = io_valid && ok_c_s && ok_x_s;
    // A flush in the same cycle blocks the issue even while still in RUN.
    assign fire_s     = issue_ok_s && (state_q == ST_RUN) && !io_flush;
    assign io_replay  = io_valid && !fire_s;
    assign use_c_s    = fire_s && io_sigs_enq_cmdq;
    assign use_x_s    = fire_s && io_sigs_enq_ximm1q;

    credit_counter #(.DEPTH(CMDQ_DEPTH)) u_cmdq_cred (
        .clk       (clk),
        .reset_n   (reset_n),
        .use_i     (use_c_s),
        .ret_i     (io_cmdq_deq),
        .cred_o    (io_cmdq_credits),
        .nonzero_o (c_nonzero_s),
        .full_o    (c_full_s),
        .ovf_o     (c_ovf_s)
    );

    credit_counter #(.DEPTH(XIMM1Q_DEPTH)) u_ximm_cred (
        .clk       (clk),
        .reset_n   (reset_n),
        .use_i     (use_x_s),
        .ret_i     (io_ximm1q_deq),
        .cred_o    (io_ximm1q_credits),
        .nonzero_o (x_nonzero_s),
        .full_o    (x_full_s),
        .ovf_o     (x_ovf_s)
    );

    // Starve counter next value: counts STALL replays, saturating at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fire_s || io_flush || !io_valid) begin
            starve_cnt_d = {SW{1'b0}};
        end else if ((state_q == ST_STALL) && io_replay && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Issue FSM with registered enqueue strobes, payloads and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            cmdq_valid_q <= 1'b0;
            ximm_valid_q <= 1'b0;
            cmd_bits_q   <= {CMD_W{1'b0}};
            imm_bits_q   <= {IMM_W{1'b0}};
            starve_cnt_q <= {SW{1'b0}};
            starve_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (io_flush) begin
                state_q <= ST_DRAIN;
            end else begin
                case (state_q)
                    ST_RUN:   state_q <= io_replay ? ST_STALL : ST_RUN;
                    ST_STALL: state_q <= (issue_ok_s || !io_valid) ? ST_RUN : ST_STALL;
                    ST_DRAIN: state_q <= (c_full_s && x_full_s) ? ST_RUN : ST_DRAIN;
                    default:  state_q <= ST_RUN;
                endcase
            end

            cmdq_valid_q <= use_c_s;
            ximm_valid_q <= use_x_s;
            cmd_bits_q   <= use_c_s ? io_cmd : cmd_bits_q;
            imm_bits_q   <= use_x_s ? io_imm : imm_bits_q;

            starve_cnt_q <= starve_cnt_d;
            if (fire_s) begin
                starve_q <= 1'b0;
            end else if (starve_cnt_d == SW'(STARVE_LIMIT)) begin
                starve_q <= 1'b1;
            end else begin
                starve_q <= starve_q;
            end

            err_q <= err_q || c_ovf_s || x_ovf_s;
        end
    end

    assign io_cmdq_valid   = cmdq_valid_q;
    assign io_cmdq_bits    = cmd_bits_q;
    assign io_ximm1q_valid = ximm_valid_q;
    assign io_ximm1q_bits  = imm_bits_q;
    assign io_starve       = starve_q;
    assign io_err          = err_q;

endmodule

// File: tb/tb_enq_issue_ctrl.sv
// Scoreboard bench for enq_issue_ctrl: stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_enq_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q;
    logic [7:0]  io_cmd;
    logic [31:0] io_imm;
    logic        io_replay;
    logic        io_cmdq_valid;
    logic [7:0]  io_cmdq_bits;
    logic        io_ximm1q_valid;
    logic [31:0] io_ximm1q_bits;
    logic        io_cmdq_deq, io_ximm1q_deq, io_flush;
    logic [2:0]  io_cmdq_credits, io_ximm1q_credits;
    logic        io_starve, io_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc_n     = 0;

    typedef struct {
        int          due;
        logic [31:0] bits;
    } exp_t;

    exp_t qc[$];
    exp_t qx[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    enq_issue_ctrl dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .io_valid           (io_valid),
        .io_sigs_enq_cmdq   (io_sigs_enq_cmdq),
        .io_sigs_enq_ximm1q (io_sigs_enq_ximm1q),
        .io_cmd             (io_cmd),
        .io_imm             (io_imm),
        .io_replay          (io_replay),
        .io_cmdq_valid      (io_cmdq_valid),
        .io_cmdq_bits       (io_cmdq_bits),
        .io_ximm1q_valid    (io_ximm1q_valid),
        .io_ximm1q_bits     (io_ximm1q_bits),
        .io_cmdq_deq        (io_cmdq_deq),
        .io_ximm1q_deq      (io_ximm1q_deq),
        .io_flush           (io_flush),
        .io_cmdq_credits    (io_cmdq_credits),
        .io_ximm1q_credits  (io_ximm1q_credits),
        .io_starve          (io_starve),
        .io_err             (io_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    task automatic flag_fail(input string name);
        total_cnt++;
        $display("FAIL %s: got strobe mismatch at cycle %0d", name, cyc_n);
    endtask

    // One stimulus cycle: drive, record expected strobes, check replay, advance past the edge.
    task automatic step(input logic v, input logic sc, input logic sx,
                        input logic [7:0] cmd, input logic [31:0] imm,
                        input logic cd, input logic xd, input logic fl,
                        input logic exp_rep);
        io_valid = v; io_sigs_enq_cmdq = sc; io_sigs_enq_ximm1q = sx;
        io_cmd = cmd; io_imm = imm;
        io_cmdq_deq = cd; io_ximm1q_deq = xd; io_flush = fl;
        if (v && !exp_rep) begin
            if (sc) qc.push_back('{cyc_n + 1, {24'h000000, cmd}});
            if (sx) qx.push_back('{cyc_n + 1, imm});
        end
        @(negedge clk);
        check("replay", {31'b0, io_replay}, {31'b0, exp_rep});
        @(posedge clk);
        #1;
        io_valid = 1'b0; io_sigs_enq_cmdq = 1'b0; io_sigs_enq_ximm1q = 1'b0;
        io_cmdq_deq = 1'b0; io_ximm1q_deq = 1'b0; io_flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every strobe must match the oldest expectation and arrive exactly on its due cycle.
    always @(negedge clk) begin
        while (qc.size() > 0 && qc[0].due < cyc_n) begin
            flag_fail("cmdq_missed");
            void'(qc.pop_front());
        end
        if (io_cmdq_valid) begin
            if (qc.size() == 0 || qc[0].due != cyc_n) flag_fail("cmdq_unexpected");
            else begin
                check("cmdq_bits", {24'h000000, io_cmdq_bits}, qc[0].bits);
                void'(qc.pop_front());
            end
        end
        while (qx.size() > 0 && qx[0].due < cyc_n) begin
            flag_fail("ximm_missed");
            void'(qx.pop_front());
        end
        if (io_ximm1q_valid) begin
            if (qx.size() == 0 || qx[0].due != cyc_n) flag_fail("ximm_unexpected");
            else begin
                check("ximm_bits", io_ximm1q_bits, qx[0].bits);
                void'(qx.pop_front());
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        io_valid = 1'b0; io_sigs_enq_cmdq = 1'b0; io_sigs_enq_ximm1q = 1'b0;
        io_cmd = 8'h00; io_imm = 32'h0;
        io_cmdq_deq = 1'b0; io_ximm1q_deq = 1'b0; io_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmdq_cred", {29'b0, io_cmdq_credits}, 32'd4);
        check("rst_ximm_cred", {29'b0, io_ximm1q_credits}, 32'd4);
        check("rst_cmdq_valid", {31'b0, io_cmdq_valid}, 32'd0);
        check("rst_ximm_valid", {31'b0, io_ximm1q_valid}, 32'd0);
        check("rst_bits", {24'b0, io_cmdq_bits} | io_ximm1q_bits, 32'd0);
        check("rst_starve", {31'b0, io_starve}, 32'd0);
        check("rst_err", {31'b0, io_err}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Four cmdq fires drain the credits; the fifth replays.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h10 + 8'(i), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h14, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_cmdq_cred", {29'b0, io_cmdq_credits}, 32'd0);
        idle(1);

        // ximm-only issue still works without cmdq credit; dual target then replays atomically.
        step(1'b1, 1'b0, 1'b1, 8'h00, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_ximm_cred_a", {29'b0, io_ximm1q_credits}, 32'd3);
        step(1'b1, 1'b1, 1'b1, 8'hAA, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_ximm_cred_b", {29'b0, io_ximm1q_credits}, 32'd3);
        check("t2_cmdq_cred", {29'b0, io_cmdq_credits}, 32'd0);
        idle(1);

        // Two returns, then fire with a simultaneous cmdq return.
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_cmdq_cred_pre", {29'b0, io_cmdq_credits}, 32'd2);
        step(1'b1, 1'b1, 1'b1, 8'h55, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_cmdq_cred", {29'b0, io_cmdq_credits}, 32'd2);
        check("t3_ximm_cred", {29'b0, io_ximm1q_credits}, 32'd2);

        // Refill, then overflow the cmdq counter.
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_cmdq_full", {29'b0, io_cmdq_credits}, 32'd4);
        check("t4_ximm_full", {29'b0, io_ximm1q_credits}, 32'd4);
        check("t4_err_pre", {31'b0, io_err}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_cred_sat", {29'b0, io_cmdq_credits}, 32'd4);
        check("t4_err_set", {31'b0, io_err}, 32'd1);
        idle(3);
        check("t4_err_sticky", {31'b0, io_err}, 32'd1);

        // Starvation: drain credits, then hold a blocked instruction.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h20 + 8'(i), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h77, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 15) check("t5_starve_pre", {31'b0, io_starve}, 32'd0);
            if (i == 16) check("t5_starve_set", {31'b0, io_starve}, 32'd1);
        end
        step(1'b1, 1'b1, 1'b0, 8'h77, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h77, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_starve_hold", {31'b0, io_starve}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'h78, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_starve_clr", {31'b0, io_starve}, 32'd0);
        check("t5_cmdq_cred", {29'b0, io_cmdq_credits}, 32'd0);

        // Flush with three outstanding entries: flush beats a would-be fire, drain until refilled.
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h90, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t6_cred_flush", {29'b0, io_cmdq_credits}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h90, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t6_cred_full", {29'b0, io_cmdq_credits}, 32'd4);
        step(1'b1, 1'b1, 1'b0, 8'h90, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h91, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_cred_after", {29'b0, io_cmdq_credits}, 32'd3);
        idle(2);

        check("sb_cmdq_empty", qc.size(), 32'd0);
        check("sb_ximm_empty", qx.size(), 32'd0);
        check("end_err", {31'b0, io_err}, 32'd1);

        reset_n = 1'b0;
        #1;
        check("rst2_err", {31'b0, io_err}, 32'd0);
        check("rst2_cmdq_cred", {29'b0, io_cmdq_credits}, 32'd4);
        check("rst2_cmdq_valid", {31'b0, io_cmdq_valid}, 32'd0);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/enq_issue_ctrl.md
# enq_issue_ctrl

Issue controller that sits between the block decoder and the two downstream command queues (cmdq, ximm1q). Each cycle it decides whether the decoded instruction can be issued, based on per-queue credit counters, or must be replayed. It enqueues the instruction into every queue it targets in the same cycle (atomic dual-enqueue). It also sequences a flush/drain phase and flags starvation.

## Interface
Parameters:
- CMDQ_DEPTH, 4: cmdq entries; the cmdq credit counter resets to this value.
- XIMM1Q_DEPTH, 4: ximm1q entries; the ximm1q credit counter resets to this value.
- CMD_W, 8: cmdq payload width.
- IMM_W, 32: ximm1q payload width.
- STARVE_LIMIT, 15: number of consecutive replay cycles that sets io_starve.

Ports:
- clk  in  1  sole clock; every flop is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- io_valid  in  1  decoder holds a decoded instruction.
- io_sigs_enq_cmdq  in  1  instruction targets cmdq.
- io_sigs_enq_ximm1q  in  1  instruction targets ximm1q.
- io_cmd  in  CMD_W  cmdq payload.
- io_imm  in  IMM_W  ximm1q payload.
- io_replay  out  1  combinational; instruction not issued this cycle.
- io_cmdq_valid  out  1  registered enqueue strobe to cmdq.
- io_cmdq_bits  out  CMD_W  registered cmdq payload.
- io_ximm1q_valid  out  1  registered enqueue strobe to ximm1q.
- io_ximm1q_bits  out  IMM_W  registered ximm1q payload.
- io_cmdq_deq  in  1  one-cycle pulse: cmdq freed one entry (credit return).
- io_ximm1q_deq  in  1  one-cycle pulse: ximm1q freed one entry.
- io_flush  in  1  level; enter drain.
- io_cmdq_credits  out  clog2(CMDQ_DEPTH+1)  current cmdq credit count.
- io_ximm1q_credits  out  clog2(XIMM1Q_DEPTH+1)  current ximm1q credit count.
- io_starve  out  1  sticky starvation flag.
- io_err  out  1  sticky credit-overflow flag.

## Operation
- ok_c = !io_sigs_enq_cmdq | (cmdq_cred != 0).
- ok_x = !io_sigs_enq_ximm1q | (ximm_cred != 0).
- fire = io_valid & ok_c & ok_x & (state == RUN).
- io_replay = io_valid & !fire.
- A valid instruction with neither sig set fires as a no-op: no enqueue, no credit change.
- On fire, each targeted queue gets its valid strobe and payload next cycle, and its credit counter decrements.
- Partial issue never happens: if either targeted queue lacks credit, neither queue is enqueued.
- Credit update per queue: next = cred - used + deq. If used and deq occur in the same cycle, the count is unchanged.
- deq while cred == DEPTH (with no use that cycle): count stays at DEPTH and io_err sets. io_err clears only on reset.
- FSM states:
  - RUN: normal issue.
  - STALL: entered from RUN when a replay occurs with io_flush low. Returns to RUN on the first cycle in which the issue condition (io_valid & ok_c & ok_x) holds again, or when io_valid drops.
  - DRAIN: entered from any state when io_flush is high. No fire; every valid replays.
  - DRAIN exits to RUN when io_flush is low and both counters equal DEPTH.
- Starve counter: increments on each replay cycle in STALL and saturates at STARVE_LIMIT. It clears on fire, on entry to DRAIN, or when io_valid is low.
- io_starve sets when the starve counter reaches STARVE_LIMIT and clears on the next fire.

## Timing
- io_replay: zero-cycle combinational path from io_valid, the sigs and state.
- Enqueue outputs: exactly 1-cycle latency after fire. Strobes are 1-cycle pulses; back-to-back fires give back-to-back strobes.
- Credits are registered. A deq in cycle N makes the credit usable for a fire in cycle N+1.
- Reset values:
  - state = RUN.
  - cmdq_cred = CMDQ_DEPTH; ximm_cred = XIMM1Q_DEPTH.
  - io_cmdq_valid = io_ximm1q_valid = 0.
  - bits = 0.
  - io_starve = io_err = 0; starve counter = 0.
- Reset asserted mid-operation: all state returns to reset values immediately. A strobe in flight is dropped.
- io_flush asserted in the same cycle as a would-be fire: flush wins; no fire, replay = io_valid.

## Structure
- Shared package: FSM state encoding (RUN=0, STALL=1, DRAIN=2) and the default depth and width constants.
- One sub-module, credit_counter, instantiated twice. Parameter: DEPTH. Inputs: use, ret. Outputs: cred, nonzero, full, ovf.

## Test plan
- Reset, then valid with cmdq-only targeting for 5 cycles and no deq (DEPTH=4) -> 4 fires with cmdq strobes one cycle later; cycle 5 replays; io_cmdq_credits = 0.
- Set both sigs with cmdq_cred=0 and ximm_cred=3 -> replay; no strobe on either queue; ximm_cred stays 3.
- Credits at 2, and fire and io_cmdq_deq in the same cycle -> cred stays 2; strobe asserted the next cycle.
- io_cmdq_deq with cred == 4 -> cred stays 4; io_err = 1 and remains 1 until reset.
- Hold valid with cmdq_cred=0 for 16 cycles -> io_starve = 1 at the 15th consecutive STALL replay; a deq followed by a fire clears it.
- Assert io_flush for 1 cycle with 3 outstanding entries -> replays until three deq pulses restore cred=4; RUN resumes and fires the following cycle.
